// File: rtl/q3_gate_sweep_ctrl.sv
// Exhaustive sweep sequencer for the muxed four-variable gate evaluator.
// Walks each function through all 16 vectors and records the SOP truth table and any SOP/POS disagreement.
module q3_gate_sweep_ctrl #(
  parameter int unsigned NUM_FUNCS = 4,
  parameter int unsigned SETTLE    = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        abort,
  output logic [1:0]  sel,
  output logic [3:0]  vec,
  input  logic        sop_in,
  input  logic        pos_in,
  output logic        busy,
  output logic        done,
  output logic [63:0] tt,
  output logic [3:0]  mismatch,
  output logic [6:0]  err_count
);

  localparam int unsigned SEL_W = 2;
  localparam int unsigned VEC_W = 4;
  localparam int unsigned CNT_W = 4;
  localparam int unsigned ERR_W = 7;
  localparam logic [SEL_W-1:0] LAST_SEL  = SEL_W'(NUM_FUNCS - 1);
  localparam logic [VEC_W-1:0] LAST_VEC  = '1;
  localparam logic [CNT_W-1:0] SETTLE_LD = CNT_W'(SETTLE);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EVAL = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [SEL_W-1:0] sel_nxt;
  logic [VEC_W-1:0] vec_nxt;
  logic [63:0]      tt_nxt;
  logic [3:0]       mismatch_nxt;
  logic [ERR_W-1:0] err_count_nxt;
  logic             busy_nxt, done_nxt;
  logic             accept_c, sample_c, last_c;

  // abort outranks both start (in IDLE) and a pending sample (in EVAL)
  assign accept_c = (state == IDLE) && start && !abort;
  assign sample_c = (state == EVAL) && !abort && (cnt == '0);
  assign last_c   = sample_c && (sel == LAST_SEL) && (vec == LAST_VEC);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept_c) state_nxt = EVAL;
      EVAL: begin
        if (abort)       state_nxt = IDLE;
        else if (last_c) state_nxt = DONE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    cnt_nxt       = cnt;
    sel_nxt       = sel;
    vec_nxt       = vec;
    tt_nxt        = tt;
    mismatch_nxt  = mismatch;
    err_count_nxt = err_count;
    busy_nxt      = (state_nxt == EVAL);
    done_nxt      = (state_nxt == DONE);

    if (accept_c) begin
      tt_nxt        = '0;
      mismatch_nxt  = '0;
      err_count_nxt = '0;
      sel_nxt       = '0;
      vec_nxt       = '0;
      cnt_nxt       = SETTLE_LD;
    end else if ((state == EVAL) && !abort) begin
      if (cnt != '0) begin
        cnt_nxt = cnt - CNT_W'(1);
      end else begin
        tt_nxt[{sel, vec}] = sop_in;
        if (sop_in != pos_in) begin
          mismatch_nxt[sel] = 1'b1;
          err_count_nxt     = err_count + ERR_W'(1);
        end
        // sel/vec freeze on the final sample so they read back the last vector
        if (!last_c) begin
          cnt_nxt = SETTLE_LD;
          vec_nxt = vec + VEC_W'(1);
          if (vec == LAST_VEC) sel_nxt = sel + SEL_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt       <= '0;
      sel       <= '0;
      vec       <= '0;
      tt        <= '0;
      mismatch  <= '0;
      err_count <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      cnt       <= cnt_nxt;
      sel       <= sel_nxt;
      vec       <= vec_nxt;
      tt        <= tt_nxt;
      mismatch  <= mismatch_nxt;
      err_count <= err_count_nxt;
      busy      <= busy_nxt;
      done      <= done_nxt;
    end
  end

endmodule
